// File: rtl/ula_pkg.sv
// ula_pkg: ALU control codes shared with the ALU control decoder, plus the
// state encoding of the multi-cycle ALU sequencer.
package ula_pkg;

   localparam logic [2:0] ALU_ADD  = 3'b000;
   localparam logic [2:0] ALU_SUB  = 3'b001;
   localparam logic [2:0] ALU_MULT = 3'b010;
   localparam logic [2:0] ALU_DIV  = 3'b011;
   localparam logic [2:0] ALU_SLT  = 3'b100;

   // ST_EXEC is the cycle after acceptance: single-cycle ops are evaluated
   // from the latched operands, iterative ops load the shift datapath.
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_EXEC,
      ST_CALC,
      ST_SIGN,
      ST_DONE
   } ula_state_t;

   // True for the operations that go through the iterative datapath when
   // the operands allow it (div by zero is short-circuited by the caller).
   function automatic logic is_iterative(input logic [2:0] op);
      return (op == ALU_MULT) || (op == ALU_DIV);
   endfunction

endpackage

// File: rtl/mult_div_iterativo.sv
// mult_div_iterativo: unsigned shift-add multiplier / restoring divider on
// operand magnitudes, one bit per step, with a final sign-correction step.
// hi/lo double as accumulator/remainder and multiplier/quotient registers.
module mult_div_iterativo
   import ula_pkg::*;
#(
   parameter int WIDTH = 32
)
(
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             step,
   input  logic             sign_fix,
   input  logic             op_div,
   input  logic             neg_q,
   input  logic             neg_r,
   input  logic [WIDTH-1:0] mag_a,
   input  logic [WIDTH-1:0] mag_b,
   output logic [WIDTH-1:0] hi_fix,
   output logic [WIDTH-1:0] lo_fix,
   output logic             last
);

   localparam int CNT_W = $clog2(WIDTH) + 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic [WIDTH-1:0]   md_q, md_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               op_div_q, op_div_d;
   logic               neg_q_q, neg_q_d;
   logic               neg_r_q, neg_r_d;

   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     shift_rem;
   logic               rem_ge;
   logic [WIDTH-1:0]   rem_diff;
   logic [2*WIDTH-1:0] prod_fix;

   // Per-step arithmetic and the sign-corrected view of the current registers
   always_comb begin
      mul_sum   = lo_q[0] ? ({1'b0, hi_q} + {1'b0, md_q}) : {1'b0, hi_q};
      shift_rem = {hi_q, lo_q[WIDTH-1]};
      rem_ge    = (shift_rem >= {1'b0, md_q});
      rem_diff  = shift_rem[WIDTH-1:0] - md_q;
      prod_fix  = neg_q_q ? -{hi_q, lo_q} : {hi_q, lo_q};
      if (op_div_q) begin
         hi_fix = neg_r_q ? -hi_q : hi_q;
         lo_fix = neg_q_q ? -lo_q : lo_q;
      end else begin
         hi_fix = prod_fix[2*WIDTH-1:WIDTH];
         lo_fix = prod_fix[WIDTH-1:0];
      end
   end

   // Next-state of the datapath registers for load / step / sign-fix
   always_comb begin
      hi_d     = hi_q;
      lo_d     = lo_q;
      md_d     = md_q;
      cnt_d    = cnt_q;
      op_div_d = op_div_q;
      neg_q_d  = neg_q_q;
      neg_r_d  = neg_r_q;
      if (load) begin
         hi_d     = '0;
         lo_d     = mag_a;
         md_d     = mag_b;
         cnt_d    = CNT_LOAD;
         op_div_d = op_div;
         neg_q_d  = neg_q;
         neg_r_d  = neg_r;
      end else if (step) begin
         if (op_div_q) begin
            if (rem_ge) begin
               hi_d = rem_diff;
               lo_d = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
               hi_d = shift_rem[WIDTH-1:0];
               lo_d = {lo_q[WIDTH-2:0], 1'b0};
            end
         end else begin
            hi_d = mul_sum[WIDTH:1];
            lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
         end
         if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_ONE;
         end
      end else if (sign_fix) begin
         hi_d = hi_fix;
         lo_d = lo_fix;
      end
   end

   // Datapath register bank
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hi_q     <= '0;
         lo_q     <= '0;
         md_q     <= '0;
         cnt_q    <= '0;
         op_div_q <= 1'b0;
         neg_q_q  <= 1'b0;
         neg_r_q  <= 1'b0;
      end else begin
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         md_q     <= md_d;
         cnt_q    <= cnt_d;
         op_div_q <= op_div_d;
         neg_q_q  <= neg_q_d;
         neg_r_q  <= neg_r_d;
      end
   end

   assign last = (cnt_q == '0);

endmodule

// File: rtl/ula_multiciclo.sv
// ula_multiciclo: multi-cycle MIPS ALU. add/sub/slt complete in one execute
// cycle; signed mult/div run iteratively into HI/LO behind a start/busy/done
// handshake so the main control FSM can stall.
module ula_multiciclo
   import ula_pkg::*;
#(
   parameter int WIDTH = 32
)
(
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       alu_con,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero
);

   ula_state_t       state_q, state_d;
   logic [2:0]       op_q, op_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             zero_q, zero_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic             dbz_q, dbz_d;

   logic [WIDTH-1:0] mag_a, mag_b;
   logic             b_is_zero;
   logic             use_iter;
   logic [WIDTH-1:0] single_res;
   logic             dp_load, dp_step, dp_sign_fix;
   logic [WIDTH-1:0] dp_hi, dp_lo;
   logic             dp_last;

   // Operand magnitudes and the decision whether the iterative path is used
   always_comb begin
      mag_a     = a_q[WIDTH-1] ? -a_q : a_q;
      mag_b     = b_q[WIDTH-1] ? -b_q : b_q;
      b_is_zero = (b_q == '0);
      use_iter  = is_iterative(op_q) && !((op_q == ALU_DIV) && b_is_zero);
   end

   // Single-cycle results; div here only happens for a zero divisor
   always_comb begin
      single_res = '0;
      case (op_q)
         ALU_ADD: single_res = a_q + b_q;
         ALU_SUB: single_res = a_q - b_q;
         ALU_SLT: single_res = {{(WIDTH-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
         ALU_DIV: single_res = '1;
         default: single_res = '0;
      endcase
   end

   mult_div_iterativo #(
      .WIDTH(WIDTH)
   ) u_mult_div (
      .clk      (clk),
      .reset    (reset),
      .load     (dp_load),
      .step     (dp_step),
      .sign_fix (dp_sign_fix),
      .op_div   (op_q == ALU_DIV),
      .neg_q    (a_q[WIDTH-1] ^ b_q[WIDTH-1]),
      .neg_r    (a_q[WIDTH-1]),
      .mag_a    (mag_a),
      .mag_b    (mag_b),
      .hi_fix   (dp_hi),
      .lo_fix   (dp_lo),
      .last     (dp_last)
   );

   // Sequencer next-state, datapath controls and output register updates
   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      a_d         = a_q;
      b_d         = b_q;
      result_d    = result_q;
      zero_d      = zero_q;
      hi_d        = hi_q;
      lo_d        = lo_q;
      dbz_d       = dbz_q;
      dp_load     = 1'b0;
      dp_step     = 1'b0;
      dp_sign_fix = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               op_d    = alu_con;
               a_d     = a;
               b_d     = b;
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            if (use_iter) begin
               dp_load = 1'b1;
               state_d = ST_CALC;
            end else begin
               result_d = single_res;
               zero_d   = (single_res == '0);
               dbz_d    = (op_q == ALU_DIV);
               if (op_q == ALU_DIV) begin
                  hi_d = a_q;
                  lo_d = '1;
               end
               state_d = ST_DONE;
            end
         end
         ST_CALC: begin
            dp_step = 1'b1;
            if (dp_last) begin
               state_d = ST_SIGN;
            end
         end
         ST_SIGN: begin
            dp_sign_fix = 1'b1;
            result_d    = dp_lo;
            zero_d      = (dp_lo == '0);
            hi_d        = dp_hi;
            lo_d        = dp_lo;
            dbz_d       = 1'b0;
            state_d     = ST_DONE;
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, latched request and architectural output registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         op_q     <= ALU_ADD;
         a_q      <= '0;
         b_q      <= '0;
         result_q <= '0;
         zero_q   <= 1'b1;
         hi_q     <= '0;
         lo_q     <= '0;
         dbz_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         a_q      <= a_d;
         b_q      <= b_d;
         result_q <= result_d;
         zero_q   <= zero_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         dbz_q    <= dbz_d;
      end
   end

   assign result      = result_q;
   assign zero        = zero_q;
   assign hi          = hi_q;
   assign lo          = lo_q;
   assign div_by_zero = dbz_q;
   assign busy        = (state_q != ST_IDLE);
   assign done        = (state_q == ST_DONE);

endmodule

// File: tb/tb_ula_multiciclo.sv
// tb_ula_multiciclo: directed vector table for ula_multiciclo plus hand-written
// sequences for start-while-busy and reset during a multiply.
module tb_ula_multiciclo;
   import ula_pkg::*;

   localparam int WIDTH = 32;

   logic             clk = 1'b0;
   logic             reset;
   logic             start;
   logic [2:0]       alu_con;
   logic [WIDTH-1:0] a, b;
   logic [WIDTH-1:0] result, hi, lo;
   logic             zero, busy, done, div_by_zero;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int accept_cyc = 0;

   typedef struct {
      string       name;
      logic [2:0]  op;
      logic [31:0] va;
      logic [31:0] vb;
      logic [31:0] exp_res;
      logic        exp_zero;
      logic [31:0] exp_hi;
      logic [31:0] exp_lo;
      logic        exp_dbz;
      int          exp_lat;
   } vec_t;

   vec_t vecs[15];

   ula_multiciclo #(.WIDTH(WIDTH)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .alu_con     (alu_con),
      .a           (a),
      .b           (b),
      .result      (result),
      .zero        (zero),
      .hi          (hi),
      .lo          (lo),
      .busy        (busy),
      .done        (done),
      .div_by_zero (div_by_zero)
   );

   // Free-running clock and cycle counter used to measure latency
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Guard against a hung run
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
      end
   endtask

   // Wait for IDLE, present a request for one cycle, record the accept edge,
   // then scramble the operand inputs so late changes would be visible.
   task automatic applyStimulus(input logic [2:0] op, input logic [31:0] va, input logic [31:0] vb);
      int guard = 0;
      @(negedge clk);
      while (busy === 1'b1 && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      alu_con = op;
      a       = va;
      b       = vb;
      start   = 1'b1;
      @(posedge clk);
      #1;
      accept_cyc = cyc;
      start   = 1'b0;
      a       = $urandom;
      b       = $urandom;
      alu_con = 3'($urandom_range(0, 7));
   endtask

   task automatic waitDone(output int lat);
      int guard = 0;
      while (done !== 1'b1 && guard < 200) begin
         @(posedge clk);
         #1;
         guard++;
      end
      if (done !== 1'b1) begin
         checkOutput("done_timeout", {31'b0, done}, 32'd1);
      end
      lat = cyc - accept_cyc;
   endtask

   task automatic runVector(input vec_t v);
      int lat;
      applyStimulus(v.op, v.va, v.vb);
      checkOutput({v.name, "_busy"}, {31'b0, busy}, 32'd1);
      waitDone(lat);
      checkOutput({v.name, "_latency"}, 32'(lat), 32'(v.exp_lat));
      checkOutput({v.name, "_result"}, result, v.exp_res);
      checkOutput({v.name, "_zero"}, {31'b0, zero}, {31'b0, v.exp_zero});
      checkOutput({v.name, "_hi"}, hi, v.exp_hi);
      checkOutput({v.name, "_lo"}, lo, v.exp_lo);
      checkOutput({v.name, "_dbz"}, {31'b0, div_by_zero}, {31'b0, v.exp_dbz});
      @(posedge clk);
      #1;
      checkOutput({v.name, "_done_pulse"}, {31'b0, done}, 32'd0);
      checkOutput({v.name, "_idle"}, {31'b0, busy}, 32'd0);
   endtask

   initial begin
      int  lat;
      logic saw_done;

      vecs[0]  = '{"add_wrap",  ALU_ADD,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 32'h0,          32'h0,          1'b0, 1};
      vecs[1]  = '{"sub_zero",  ALU_SUB,  32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1, 32'h0,          32'h0,          1'b0, 1};
      vecs[2]  = '{"slt_true",  ALU_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 32'h0,          32'h0,          1'b0, 1};
      vecs[3]  = '{"slt_false", ALU_SLT,  32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0,          32'h0,          1'b0, 1};
      vecs[4]  = '{"rsv_101",   3'b101,   32'h0000_000C, 32'h0000_0022, 32'h0000_0000, 1'b1, 32'h0,          32'h0,          1'b0, 1};
      vecs[5]  = '{"mult_neg",  ALU_MULT, 32'hFFFF_FFFD, 32'h4000_0000, 32'h4000_0000, 1'b0, 32'hFFFF_FFFF, 32'h4000_0000, 1'b0, 34};
      vecs[6]  = '{"add_keep",  ALU_ADD,  32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 1'b0, 32'hFFFF_FFFF, 32'h4000_0000, 1'b0, 1};
      vecs[7]  = '{"mult_pos",  ALU_MULT, 32'h0000_0006, 32'h0000_0007, 32'h0000_002A, 1'b0, 32'h0000_0000, 32'h0000_002A, 1'b0, 34};
      vecs[8]  = '{"div_neg",   ALU_DIV,  32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 34};
      vecs[9]  = '{"div_minm1", ALU_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 32'h0000_0000, 32'h8000_0000, 1'b0, 34};
      vecs[10] = '{"div_zero",  ALU_DIV,  32'h0000_0009, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 32'h0000_0009, 32'hFFFF_FFFF, 1'b1, 1};
      vecs[11] = '{"sub_neg",   ALU_SUB,  32'h0000_0003, 32'h0000_000A, 32'hFFFF_FFF9, 1'b0, 32'h0000_0009, 32'hFFFF_FFFF, 1'b0, 1};
      vecs[12] = '{"div_rpos",  ALU_DIV,  32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, 34};
      vecs[13] = '{"rsv_111",   3'b111,   32'h1234_5678, 32'h0000_0001, 32'h0000_0000, 1'b1, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, 1};
      vecs[14] = '{"mult_min",  ALU_MULT, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1, 32'h4000_0000, 32'h0000_0000, 1'b0, 34};

      reset   = 1'b1;
      start   = 1'b0;
      alu_con = 3'b000;
      a       = '0;
      b       = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      checkOutput("rst_result", result, 32'h0);
      checkOutput("rst_zero", {31'b0, zero}, 32'd1);
      checkOutput("rst_hi", hi, 32'h0);
      checkOutput("rst_lo", lo, 32'h0);
      checkOutput("rst_busy", {31'b0, busy}, 32'd0);
      checkOutput("rst_done", {31'b0, done}, 32'd0);
      checkOutput("rst_dbz", {31'b0, div_by_zero}, 32'd0);

      for (int i = 0; i < 15; i++) begin
         runVector(vecs[i]);
      end

      // A start pulsed mid-multiply must be dropped, not queued
      applyStimulus(ALU_MULT, 32'hFFFF_FFFD, 32'h4000_0000);
      repeat (5) @(negedge clk);
      alu_con = ALU_ADD;
      a       = 32'h1;
      b       = 32'h1;
      start   = 1'b1;
      @(negedge clk);
      start   = 1'b0;
      waitDone(lat);
      checkOutput("ign_latency", 32'(lat), 32'd34);
      checkOutput("ign_result", result, 32'h4000_0000);
      checkOutput("ign_hi", hi, 32'hFFFF_FFFF);
      checkOutput("ign_lo", lo, 32'h4000_0000);
      repeat (4) @(posedge clk);
      #1;
      checkOutput("ign_no_queue", {31'b0, busy}, 32'd0);

      // Leave div_by_zero set so the reset abort below has something to clear
      runVector(vecs[10]);

      // Asynchronous reset partway through a multiply
      applyStimulus(ALU_MULT, 32'h0000_0006, 32'h0000_0007);
      repeat (9) @(posedge clk);
      #2;
      checkOutput("pre_rst_busy", {31'b0, busy}, 32'd1);
      reset = 1'b1;
      #1;
      checkOutput("abort_result", result, 32'h0);
      checkOutput("abort_zero", {31'b0, zero}, 32'd1);
      checkOutput("abort_hi", hi, 32'h0);
      checkOutput("abort_lo", lo, 32'h0);
      checkOutput("abort_busy", {31'b0, busy}, 32'd0);
      checkOutput("abort_dbz", {31'b0, div_by_zero}, 32'd0);
      saw_done = done;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         saw_done = saw_done | done;
      end
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         saw_done = saw_done | done;
      end
      checkOutput("abort_no_done", {31'b0, saw_done}, 32'd0);

      runVector('{"post_rst_add", ALU_ADD, 32'h0000_0001, 32'h0000_0001, 32'h0000_0002, 1'b0, 32'h0, 32'h0, 1'b0, 1});

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ula_multiciclo.md
# ula_multiciclo

Multi-cycle ALU of the MIPS datapath: the execution unit on the consumer end of the 3-bit ALU control code driven by the ALU control decoder. It performs add, sub and slt in one cycle, and signed mult/div iteratively into HI/LO. It uses a start/busy/done handshake, so the main control FSM stalls while a mult/div is in flight.

## Interface

Parameters:

- WIDTH, 32, operand/result width. Must be ≥ 4.

Ports:

- clk  in  1  single clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  request; sampled only when busy=0
- alu_con  in  3  operation code: 000 add, 001 sub, 010 mult, 011 div, 100 slt, 101–111 reserved
- a  in  WIDTH  operand A (rs), captured at an accepted start
- b  in  WIDTH  operand B (rt/imm), captured at an accepted start
- result  out  WIDTH  registered result
- zero  out  1  registered (result == 0)
- hi  out  WIDTH  HI register (mult upper half / div remainder)
- lo  out  WIDTH  LO register (mult lower half / div quotient)
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse, high in the DONE state
- div_by_zero  out  1  registered flag, updated at every completion

## Operation

- States:
  - IDLE: accepts start; a, b and alu_con are latched.
  - CALC: WIDTH iterations.
  - SIGN: one cycle of sign correction.
  - DONE: one cycle, then returns to IDLE unconditionally.
- Acceptance: start is accepted only in IDLE. Start while busy=1 (CALC, SIGN, DONE) is ignored, not queued. Operand changes after acceptance have no effect.
- add/sub: two's-complement, wrap modulo 2^WIDTH, no overflow trap. Path is IDLE→DONE.
- slt: signed compare; result = 1 if a<b, else 0. Path is IDLE→DONE.
- Reserved codes: result = 0, zero = 1. Path is IDLE→DONE. hi and lo are unchanged.
- mult: {hi,lo} = signed 2·WIDTH product. Operands are converted to magnitudes, multiplied by shift-add (one bit per cycle, WIDTH cycles), then negated in SIGN if sign(a)^sign(b). result = lo.
- div: restoring division on magnitudes, one quotient bit per cycle (WIDTH cycles).
  - Quotient sign is sign(a)^sign(b); remainder sign is sign(a). Truncation is toward zero.
  - lo = quotient, hi = remainder, result = lo.
  - Most-negative / −1: lo = 0x8000_0000 (for WIDTH=32), hi = 0.
- div with b = 0: CALC is skipped; path is IDLE→DONE. hi = a, lo = all ones, result = all ones, div_by_zero = 1.
- result, zero and div_by_zero update on the edge entering DONE. They hold until the next completion.
- add/sub/slt/reserved never modify hi or lo.

## Timing

- Reset values: state IDLE; result, hi, lo = 0; zero = 1; busy, done, div_by_zero = 0.
- Single-cycle ops (and div-by-zero): with start accepted at edge k, done = 1 and result is valid during the cycle after edge k+1. busy = 1 from edge k to edge k+2.
- mult/div: start accepted at edge k; CALC occupies edges k+1..k+WIDTH; SIGN is at edge k+WIDTH+1; done = 1 after edge k+WIDTH+2.
  - Latency is WIDTH+2 cycles from the accept edge to done, which is 34 for WIDTH=32.
- Back-to-back: the earliest next accept is the first cycle after done falls, i.e. the IDLE cycle.
- Reset asserted mid-operation: immediate abort to reset values, with no done pulse.
- Iteration counter: $clog2(WIDTH)+1 bits. It loads WIDTH−1 on entering CALC and CALC exits on 0.

## Structure

- Shared package ula_pkg: ALU_ADD/SUB/MULT/DIV/SLT code constants (3-bit), shared with the ALU control decoder, and the state encoding.
- One sub-module, mult_div_iterativo: the magnitude/shift datapath and iteration counter, with a load/step/sign-fix interface.
- The top level holds the FSM, the single-cycle ops and the output registers.

## Test plan

- Reset values: assert reset mid-mult at cycle 10.
  - Outputs return to reset values asynchronously.
  - No done pulse.
  - A new start after release works.
- add: 0x7FFF_FFFF + 1 → result 0x8000_0000, done one cycle after accept.
- sub: 5 − 5 → result 0, zero = 1.
- slt: a = −1, b = 1 → result 1; the swapped order gives 0.
- mult: −3 × 0x4000_0000 → hi = 0xFFFF_FFFF, lo = 0x4000_0000, done exactly 34 cycles after accept. A start pulsed during busy is ignored.
- div:
  - −7 / 2 → lo = −3, hi = −1.
  - 0x8000_0000 / −1 → lo = 0x8000_0000, hi = 0.
  - 9 / 0 → lo = 0xFFFF_FFFF, hi = 9, div_by_zero = 1, done one cycle after accept.
